// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage in-order MIPS pipeline (ID -> EX -> MEM).
// It registers the decoded instruction from ID, computes the ALU result and
// issues the data-SRAM request so read data returns while the instruction is in MEM.
// It owns HI/LO and a 32-step restoring divider, and holds the pipeline while a
// divide is in progress.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        per-stage stop bits (1 = stop); bit 2 = EX, bit 3 = MEM
//   id_to_ex_bus      decoded instruction from ID (147 bits)
//   ex_to_mem_bus     instruction + result handed to MEM (81 bits)
//   data_sram_*       data SRAM enable, byte write enables, byte address, store data
//   stallreq_for_ex   divider asks for EX to be held
//   ex_if_write_data, ex_reg_id, ex_write_data   forwarding path back to ID
//   ex_is_load        instruction in EX is a load (load-use hazard detection)
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [146:0] id_to_ex_bus,
  output logic [80:0]  ex_to_mem_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex,
  output logic         ex_if_write_data,
  output logic [4:0]   ex_reg_id,
  output logic [31:0]  ex_write_data,
  output logic         ex_is_load
);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  logic [146:0] id_ex_q, id_ex_d;
  logic [31:0]  hi_q, hi_d, lo_q, lo_d;
  div_state_e   div_state_q, div_state_d;
  logic [4:0]   div_cnt_q, div_cnt_d;
  logic [31:0]  div_rem_q, div_rem_d;
  logic [31:0]  div_quo_q, div_quo_d;
  logic [31:0]  div_dvs_q, div_dvs_d;
  logic         div_qneg_q, div_qneg_d;
  logic         div_rneg_q, div_rneg_d;

  logic [31:0] pc, store_data, src1, src2;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic [4:0]  ram_op;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;

  assign {pc, alu_op, md_op, ram_op, sel_rf_res, rf_we, rf_waddr,
          store_data, src1, src2} = id_ex_q;

  // Only the EX and MEM stop bits matter here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

  logic        is_load, is_store, is_div, is_sdiv;
  logic [31:0] mem_addr, alu_result, ex_result;
  logic [63:0] prod_s, prod_u;
  logic [33:0] div_trial;
  logic [31:0] quo_fix, rem_fix;

  assign is_load  = ram_op[4];
  assign is_store = ram_op[3];
  assign is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign is_sdiv  = (md_op == MD_DIV);
  assign mem_addr = src1 + src2;

  assign prod_s = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  // Restoring step: a negative trial difference (bit 33 set) means "don't subtract".
  assign div_trial = {1'b0, div_rem_q, div_quo_q[31]} - {2'b00, div_dvs_q};
  assign quo_fix   = div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q;
  assign rem_fix   = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;

  // Input register: a stalled EX with a running MEM turns into a bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[2] && !stall[3]) begin
      id_ex_d = '0;
    end else if (!stall[2]) begin
      id_ex_d = id_to_ex_bus;
    end
  end

  // ALU; shifts take their amount from src1[4:0] and shift src2.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'd0:    alu_result = src1 + src2;
      4'd1:    alu_result = src1 - src2;
      4'd2:    alu_result = ($signed(src1) < $signed(src2)) ? 32'd1 : 32'd0;
      4'd3:    alu_result = (src1 < src2) ? 32'd1 : 32'd0;
      4'd4:    alu_result = src1 & src2;
      4'd5:    alu_result = src1 | src2;
      4'd6:    alu_result = src1 ^ src2;
      4'd7:    alu_result = ~(src1 | src2);
      4'd8:    alu_result = src2 << src1[4:0];
      4'd9:    alu_result = src2 >> src1[4:0];
      4'd10:   alu_result = $signed(src2) >>> src1[4:0];
      4'd11:   alu_result = {src2[15:0], 16'd0};
      4'd12:   alu_result = src1;
      default: alu_result = 32'd0;
    endcase
  end

  // Result select: memory ops report their address, mfhi/mflo read HI/LO.
  always_comb begin
    ex_result = alu_result;
    if (is_load || is_store) begin
      ex_result = mem_addr;
    end else if (md_op == MD_MFHI) begin
      ex_result = hi_q;
    end else if (md_op == MD_MFLO) begin
      ex_result = lo_q;
    end
  end

  // SRAM request: narrow stores replicate their data across all byte lanes.
  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = store_data;
    case (ram_op[1:0])
      2'b00: begin
        data_sram_wdata = {4{store_data[7:0]}};
        if (is_store) data_sram_wen = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        data_sram_wdata = {2{store_data[15:0]}};
        if (is_store) data_sram_wen = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (is_store) data_sram_wen = 4'b1111;
      end
      default: data_sram_wen = 4'b0000;
    endcase
  end

  assign data_sram_en   = is_load | is_store;
  assign data_sram_addr = mem_addr;

  // Divider FSM: latch magnitudes, run 32 shift-subtract steps, then wait in
  // DONE until EX is allowed to advance.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_dvs_d   = div_dvs_q;
    div_qneg_d  = div_qneg_q;
    div_rneg_d  = div_rneg_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (is_div) begin
          div_quo_d   = (is_sdiv && src1[31]) ? (32'd0 - src1) : src1;
          div_dvs_d   = (is_sdiv && src2[31]) ? (32'd0 - src2) : src2;
          div_rem_d   = 32'd0;
          div_cnt_d   = 5'd0;
          div_qneg_d  = is_sdiv && (src1[31] ^ src2[31]);
          div_rneg_d  = is_sdiv && src1[31];
          div_state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_quo_d = {div_quo_q[30:0], ~div_trial[33]};
        div_rem_d = div_trial[33] ? {div_rem_q[30:0], div_quo_q[31]} : div_trial[31:0];
        if (div_cnt_q == 5'd31) begin
          div_state_d = DIV_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 5'd1;
        end
      end
      DIV_DONE: begin
        if (!stall[2]) div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  // HI/LO update only as the producing instruction leaves EX.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall[2]) begin
      if (md_op == MD_MULT) begin
        {hi_d, lo_d} = prod_s;
      end else if (md_op == MD_MULTU) begin
        {hi_d, lo_d} = prod_u;
      end else if (div_state_q == DIV_DONE) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_dvs_q   <= '0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
    end else begin
      id_ex_q     <= id_ex_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_dvs_q   <= div_dvs_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
    end
  end

  assign stallreq_for_ex  = ((div_state_q == DIV_IDLE) && is_div) || (div_state_q == DIV_BUSY);
  assign ex_if_write_data = rf_we;
  assign ex_reg_id        = rf_waddr;
  assign ex_write_data    = ex_result;
  assign ex_is_load       = is_load;

  assign ex_to_mem_bus = {ram_op, pc, data_sram_en, data_sram_wen,
                          sel_rf_res, rf_we, rf_waddr, ex_result};

endmodule
